// File: rtl/fsm_bus_ctrl.sv
// rtl/fsm_bus_ctrl.sv - shared FLASH/SRAM bus sequencer with wait states, turnaround and ready timeout
module fsm_bus_ctrl #(
   parameter int AW          = 26,
   parameter int DW          = 32,
   parameter int FDW         = 16,
   parameter int T_SETUP     = 2,
   parameter int T_SRAM      = 3,
   parameter int T_FLASH_RD  = 6,
   parameter int T_FLASH_WR  = 8,
   parameter int T_HOLD      = 1,
   parameter int T_TURN      = 2,
   parameter int RDY_TIMEOUT = 255
) (
   input  logic            sys0_clk,
   input  logic            sys0_rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic            req_sel,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_be,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_timeout,
   output logic [AW-1:0]   bus_a,
   output logic [DW-1:0]   bus_d_o,
   output logic            bus_d_oe,
   input  logic [DW-1:0]   bus_d_i,
   output logic            flash_ce_n,
   output logic            flash_oe_n,
   output logic            flash_we_n,
   input  logic            flash_rdybsyn_i,
   output logic            sram_ce_n,
   output logic            sram_oe_n,
   output logic            sram_we_n,
   output logic [DW/8-1:0] sram_bw_n
);
   localparam int BW = DW / 8;
   // Counters load duration-1 and count down to zero; zero-length setup/strobe is stretched to one cycle.
   localparam logic [7:0] SETUP_LD = 8'(((T_SETUP    == 0) ? 1 : T_SETUP)    - 1);
   localparam logic [7:0] SRAM_LD  = 8'(((T_SRAM     == 0) ? 1 : T_SRAM)     - 1);
   localparam logic [7:0] FRD_LD   = 8'(((T_FLASH_RD == 0) ? 1 : T_FLASH_RD) - 1);
   localparam logic [7:0] FWR_LD   = 8'(((T_FLASH_WR == 0) ? 1 : T_FLASH_WR) - 1);
   localparam logic [7:0] HOLD_LD  = 8'((T_HOLD == 0) ? 0 : T_HOLD - 1);
   localparam logic [7:0] TURN_LD  = 8'((T_TURN == 0) ? 0 : T_TURN - 1);
   localparam logic [7:0] RDY_LD   = 8'(RDY_TIMEOUT - 1);
   localparam logic [DW-1:0] FMASK = ~({DW{1'b1}} << FDW);

   typedef enum logic [2:0] {IDLE, TURN, SETUP, STROBE, WAITRDY, HOLD} state_t;

   state_t          state, state_nxt;
   logic [7:0]      cnt, cnt_nxt;
   logic            done, to_set, accept, need_turn, active, strobing;
   logic [AW-1:0]   a_q;
   logic [DW-1:0]   wd_q, rd_q, rd_src;
   logic [BW-1:0]   be_q;
   logic            wr_q, sel_q, to_q, prev_read, prev_sel;
   logic            rdy_s1, rdy_s2;

   assign req_ready = (state == IDLE);
   assign accept    = req_ready && req_valid;
   assign need_turn = prev_read && (req_write || (req_sel != prev_sel)) && (T_TURN > 0);
   assign active    = (state == SETUP) || (state == STROBE) || (state == WAITRDY) || (state == HOLD);
   assign strobing  = (state == STROBE) || (state == WAITRDY);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done      = 1'b0;
      to_set    = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            state_nxt = need_turn ? TURN : SETUP;
            cnt_nxt   = need_turn ? TURN_LD : SETUP_LD;
         end
         TURN: if (cnt == 8'd0) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
         end else cnt_nxt = cnt - 8'd1;
         SETUP: if (cnt == 8'd0) begin
            state_nxt = STROBE;
            cnt_nxt   = sel_q ? SRAM_LD : (wr_q ? FWR_LD : FRD_LD);
         end else cnt_nxt = cnt - 8'd1;
         STROBE, WAITRDY: begin
            if (state == STROBE && cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else if (state == STROBE && !sel_q && !rdy_s2) begin
               state_nxt = WAITRDY;
               cnt_nxt   = RDY_LD;
            end else if (state == WAITRDY && !rdy_s2 && cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               to_set    = (state == WAITRDY) && !rdy_s2;
               state_nxt = (T_HOLD == 0) ? IDLE : HOLD;
               cnt_nxt   = HOLD_LD;
               done      = (T_HOLD == 0);
            end
         end
         HOLD: if (cnt == 8'd0) begin
            state_nxt = IDLE;
            done      = 1'b1;
         end else cnt_nxt = cnt - 8'd1;
         default: state_nxt = IDLE;
      endcase
   end

   // Read data is taken on the final strobe-low cycle, which may be the cycle that ends the strobe.
   assign rd_src = (strobing ? bus_d_i : rd_q) & (sel_q ? {DW{1'b1}} : FMASK);

   always_ff @(posedge sys0_clk) begin
      if (sys0_rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         a_q         <= '0;
         wd_q        <= '0;
         rd_q        <= '0;
         be_q        <= '0;
         wr_q        <= 1'b0;
         sel_q       <= 1'b0;
         to_q        <= 1'b0;
         prev_read   <= 1'b0;
         prev_sel    <= 1'b0;
         rdy_s1      <= 1'b1;
         rdy_s2      <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_data    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rdy_s1    <= flash_rdybsyn_i;
         rdy_s2    <= rdy_s1;
         rsp_valid <= done;
         if (accept) begin
            a_q   <= req_addr;
            wd_q  <= req_sel ? req_wdata : (req_wdata & FMASK);
            be_q  <= req_be;
            wr_q  <= req_write;
            sel_q <= req_sel;
            to_q  <= 1'b0;
         end
         if (to_set) to_q <= 1'b1;
         if (strobing && !wr_q) rd_q <= bus_d_i;
         if (done) begin
            rsp_timeout <= to_q || to_set;
            rsp_data    <= (wr_q || to_q || to_set) ? '0 : rd_src;
            prev_read   <= !wr_q;
            prev_sel    <= sel_q;
         end
      end
   end

   assign bus_a      = a_q;
   assign bus_d_o    = wd_q;
   assign bus_d_oe   = active && wr_q;
   assign flash_ce_n = !(active && !sel_q);
   assign sram_ce_n  = !(active && sel_q);
   assign flash_oe_n = !(strobing && !sel_q && !wr_q);
   assign flash_we_n = !(strobing && !sel_q && wr_q);
   assign sram_oe_n  = !(strobing && sel_q && !wr_q);
   assign sram_we_n  = !(strobing && sel_q && wr_q);
   assign sram_bw_n  = (active && sel_q && wr_q) ? ~be_q : {BW{1'b1}};
endmodule

// File: tb/tb_fsm_bus_ctrl.sv
// tb/tb_fsm_bus_ctrl.sv - directed scoreboard bench for fsm_bus_ctrl
module tb_fsm_bus_ctrl;
   logic        clk = 1'b0;
   logic        sys0_rst;
   logic        req_valid, req_ready, req_write, req_sel;
   logic [25:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_data;
   logic [25:0] bus_a;
   logic [31:0] bus_d_o, bus_d_i;
   logic        bus_d_oe;
   logic        flash_ce_n, flash_oe_n, flash_we_n, flash_rdybsyn_i;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [3:0]  sram_bw_n;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          lat;
      logic [31:0] data;
      logic        to;
      int          strobes;
      logic [31:0] wbus;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mem [0:1023];

   fsm_bus_ctrl dut (
      .sys0_clk(clk), .sys0_rst(sys0_rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_sel(req_sel),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .bus_a(bus_a), .bus_d_o(bus_d_o), .bus_d_oe(bus_d_oe), .bus_d_i(bus_d_i),
      .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
      .flash_rdybsyn_i(flash_rdybsyn_i),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_bw_n(sram_bw_n)
   );

   always #5 clk = ~clk;

   // Device models: byte-lane SRAM and a FLASH that always returns a fixed 32-bit pattern.
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         for (int b = 0; b < 4; b++)
            if (!sram_bw_n[b]) mem[bus_a[9:0]][b*8 +: 8] <= bus_d_o[b*8 +: 8];
      end
   end
   assign bus_d_i = (!sram_ce_n && !sram_oe_n)   ? mem[bus_a[9:0]] :
                    (!flash_ce_n && !flash_oe_n) ? 32'hCAFE_1234 : 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // busy_extra < 0 leaves ready high; otherwise ready is held low until that many strobe cycles past nominal.
   task automatic run_req(input string tag, input logic wr, input logic sel, input logic [25:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int busy_extra,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_to,
                          input int exp_strobes);
      exp_t e;
      int cyc, waits, strobe_n, pre_n, viol, bw_bad, t_nom;
      logic [31:0] wbus;
      logic oe_at;
      e.tag = tag; e.lat = exp_lat; e.data = exp_data; e.to = exp_to; e.strobes = exp_strobes;
      e.wbus = wr ? (sel ? wd : (wd & 32'h0000_FFFF)) : 32'h0;
      sb.push_back(e);
      t_nom = sel ? 3 : (wr ? 8 : 6);
      if (busy_extra >= 0) flash_rdybsyn_i = 1'b0;
      req_valid = 1'b1; req_write = wr; req_sel = sel; req_addr = addr; req_wdata = wd; req_be = be;
      waits = 0;
      while (!req_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      check({tag, " accept"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1; strobe_n = 0; pre_n = 0; viol = 0; bw_bad = 0; wbus = 32'h0; oe_at = 1'b0;
      while (!rsp_valid && cyc < 2000) begin
         if (!sram_we_n || !sram_oe_n || !flash_we_n || !flash_oe_n) begin
            strobe_n++;
            if (strobe_n == 1) begin
               wbus  = bus_d_o;
               oe_at = bus_d_oe;
            end
         end else if ((!sram_ce_n || !flash_ce_n) && strobe_n == 0) pre_n++;
         if ((!sram_ce_n && !flash_ce_n) || (!sram_oe_n && !sram_we_n) || (!flash_oe_n && !flash_we_n))
            viol++;
         if (!sram_ce_n && wr && sel) begin
            if (sram_bw_n !== ~be) bw_bad++;
         end else if (sram_bw_n !== 4'hF) bw_bad++;
         if (busy_extra >= 0 && strobe_n == t_nom + busy_extra) flash_rdybsyn_i = 1'b1;
         @(negedge clk);
         cyc++;
      end
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      e = sb.pop_front();
      check({e.tag, " latency"}, 32'(cyc), 32'(e.lat));
      check({e.tag, " strobe cycles"}, 32'(strobe_n), 32'(e.strobes));
      check({e.tag, " setup cycles"}, 32'(pre_n), 32'd2);
      check({e.tag, " timeout"}, 32'(rsp_timeout), 32'(e.to));
      if (!wr || e.to) check({e.tag, " rsp_data"}, rsp_data, e.data);
      check({e.tag, " bus_d_oe at strobe"}, 32'(oe_at), 32'(wr));
      if (wr) check({e.tag, " write bus data"}, wbus, e.wbus);
      check({e.tag, " exclusive strobes"}, 32'(viol), 32'd0);
      check({e.tag, " byte lanes"}, 32'(bw_bad), 32'd0);
      check({e.tag, " released at rsp"}, {25'd0, bus_d_oe, flash_ce_n, flash_oe_n, flash_we_n,
                                          sram_ce_n, sram_oe_n, sram_we_n}, 32'h3F);
      check({e.tag, " ready at rsp"}, 32'(req_ready), 32'd1);
      flash_rdybsyn_i = 1'b1;
   endtask

   initial begin
      int waits, rv;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      sys0_rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_sel = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0; flash_rdybsyn_i = 1'b1;
      repeat (3) @(negedge clk);
      check("reset ready/valid/timeout", {29'd0, req_ready, rsp_valid, rsp_timeout}, 32'h4);
      check("reset rsp_data", rsp_data, 32'h0);
      check("reset bus_a", 32'(bus_a), 32'h0);
      check("reset bus_d_o", bus_d_o, 32'h0);
      check("reset strobes", {21'd0, bus_d_oe, flash_ce_n, flash_oe_n, flash_we_n,
                              sram_ce_n, sram_oe_n, sram_we_n, sram_bw_n}, 32'h3FF);
      sys0_rst = 1'b0;
      @(negedge clk);

      run_req("sram wr",     1, 1, 26'h100, 32'hDEADBEEF, 4'hF, -1, 7, 32'h0, 0, 3);
      run_req("sram rd",     0, 1, 26'h100, 32'h0,        4'hF, -1, 7, 32'hDEADBEEF, 0, 3);
      run_req("sram wr turn",1, 1, 26'h104, 32'h12345678, 4'hF, -1, 9, 32'h0, 0, 3);
      run_req("sram wr be5", 1, 1, 26'h108, 32'hA5A5A5A5, 4'h5, -1, 7, 32'h0, 0, 3);
      run_req("sram rd be5", 0, 1, 26'h108, 32'h0,        4'hF, -1, 7, 32'h00A500A5, 0, 3);
      run_req("flash rd busy", 0, 0, 26'h040, 32'h0,      4'hF, 10, 24, 32'h0000_1234, 0, 18);
      run_req("flash wr tmo",  1, 0, 26'h044, 32'h98765432, 4'hF, 100000, 269, 32'h0, 1, 263);
      run_req("sram rd 2",   0, 1, 26'h100, 32'h0,        4'hF, -1, 7, 32'hDEADBEEF, 0, 3);

      // Abort an SRAM write mid-strobe; the previous access was a read, so it enters via TURN.
      req_valid = 1'b1; req_write = 1'b1; req_sel = 1'b1; req_addr = 26'h200;
      req_wdata = 32'h11111111; req_be = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      waits = 0;
      while (sram_we_n && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      check("abort reached strobe", 32'(sram_we_n), 32'd0);
      sys0_rst = 1'b1;
      @(negedge clk);
      check("abort strobes", {21'd0, bus_d_oe, flash_ce_n, flash_oe_n, flash_we_n,
                              sram_ce_n, sram_oe_n, sram_we_n, sram_bw_n}, 32'h3FF);
      sys0_rst = 1'b0;
      rv = 0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid) rv++;
         @(negedge clk);
      end
      check("abort no rsp", 32'(rv), 32'd0);

      run_req("post-reset wr", 1, 1, 26'h10C, 32'h0BADF00D, 4'hF, -1, 7, 32'h0, 0, 3);
      run_req("post-reset rd", 0, 1, 26'h10C, 32'h0,        4'hF, -1, 7, 32'h0BADF00D, 0, 3);
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fsm_bus_ctrl.md
# fsm_bus_ctrl

Parametrised controller for the shared FLASH/SRAM bus, where both devices share one address bus and one data bus. It accepts single-word requests from the FTop control plane on a valid/ready handshake. It sequences chip-enable, output-enable and write-enable strobes with per-target programmable wait states, and inserts bus turnaround cycles where a direction change needs them. It honours the FLASH ready/busy pin with a timeout. The board top level owns the tristate buffer, so this block never touches the inout pins directly.

## Interface
- AW, 26, address width
- DW, 32, SRAM/bus data width (multiple of 8)
- FDW, 16, FLASH data width (≤ DW, uses bus_d[FDW-1:0])
- T_SETUP, 2, address/CE setup cycles before strobe (0 treated as 1)
- T_SRAM, 3, SRAM strobe cycles, read and write (0 treated as 1)
- T_FLASH_RD, 6, FLASH OE strobe cycles (0 treated as 1)
- T_FLASH_WR, 8, FLASH WE strobe cycles (0 treated as 1)
- T_HOLD, 1, post-strobe address/data hold cycles (0 allowed)
- T_TURN, 2, turnaround cycles (0 allowed)
- RDY_TIMEOUT, 255, max WAITRDY cycles (1..255)

Ports:
- sys0_clk  in  1  single clock; all logic on rising edge
- sys0_rst  in  1  reset; **synchronous, active-high**
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer when both are high at an edge
- req_write  in  1  1 = write, 0 = read
- req_sel  in  1  0 = FLASH, 1 = SRAM
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- req_be  in  DW/8  SRAM byte enables; ignored for FLASH
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_data  out  DW  read data, valid with rsp_valid; FLASH is zero-extended
- rsp_timeout  out  1  qualifies rsp_valid: FLASH ready timeout occurred
- bus_a  out  AW  shared address
- bus_d_o  out  DW  write data to the top-level tristate
- bus_d_oe  out  1  drive enable for bus_d
- bus_d_i  in  DW  bus data from the pins
- flash_ce_n, flash_oe_n, flash_we_n  out  1 each  FLASH strobes, active-low
- flash_rdybsyn_i  in  1  FLASH ready (async; high = ready)
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low
- sram_bw_n  out  DW/8  SRAM byte-lane enables, active-low

## Operation
- FSM states: IDLE, TURN, SETUP, STROBE, WAITRDY, HOLD.
- Values captured at acceptance and held until the request completes:
  - addr, wdata, be, write, sel.
  - The prev_read/prev_sel record from the prior access.
- IDLE to TURN on accept, when the prior completed access was a read AND (the new access is a write OR sel differs), and T_TURN > 0. Otherwise IDLE to SETUP.
- TURN: all CE/OE/WE high, bus_d_oe = 0, lasts T_TURN cycles, then SETUP.
- SETUP:
  - bus_a is driven and the selected CE is low; OE/WE stay high.
  - For writes, bus_d_oe = 1 and bus_d_o = wdata. For FLASH writes, bits above FDW are 0.
  - sram_bw_n = ~be on SRAM writes, all-ones otherwise.
  - Lasts T_SETUP cycles.
- STROBE: OE low (read) or WE low (write) for T_SRAM, T_FLASH_RD or T_FLASH_WR cycles.
- End of STROBE, SRAM: go to HOLD.
- End of STROBE, FLASH:
  - If the synchronised ready bit is 1, go to HOLD.
  - Otherwise go to WAITRDY, with the strobe held low.
- WAITRDY:
  - Counts cycles; goes to HOLD when ready = 1.
  - At RDY_TIMEOUT cycles, goes to HOLD with the timeout flag set.
- Read data capture:
  - Captured from bus_d_i on the last cycle the strobe is low.
  - FLASH read data is masked to FDW bits.
  - On a timeout, rsp_data = 0.
- HOLD: strobe high, CE low, address and write data still driven, for T_HOLD cycles. The block then returns to IDLE and releases CE and bus_d_oe.
- rsp_valid pulses for exactly the first IDLE cycle; rsp_timeout is valid alongside it.
- flash_rdybsyn_i passes through a 2-flop synchroniser, with reset value 1.
- Wait-state counters are 8-bit and count down.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_timeout = 0, rsp_data = 0, bus_a = 0, bus_d_o = 0, bus_d_oe = 0, all *_n = 1, prev_read = 0.
- Reset mid-operation: all strobes go high and bus_d_oe goes to 0 at the reset edge. No rsp_valid is produced for the aborted access.
- Accept at edge E0. Without TURN, rsp_valid is high in cycle E0 + 1 + T_SETUP + T_strobe + W + T_HOLD, where W is the number of WAITRDY cycles. TURN adds T_TURN cycles.
- A back-to-back request can be accepted in the same cycle as rsp_valid.
- A request presented while the block is busy is stalled (req_ready = 0); it is never dropped.
- Only one of flash_ce_n or sram_ce_n is ever low. OE and WE are never low together.

## Test plan
- Reset, then SRAM write: addr 0x000100, data 0xDEADBEEF, be 0xF, defaults. Expect sram_we_n low for 3 cycles after 2 SETUP cycles. Expect rsp_valid exactly 7 cycles after accept and bus_d_oe low the next cycle.
- SRAM read of 0x000100 with the model returning 0xDEADBEEF. Expect no TURN, rsp_data = 0xDEADBEEF, latency 7. A following write to 0x000104 inserts 2 TURN cycles, giving latency 9.
- SRAM write with be 0x5. Expect sram_bw_n = 0xA throughout SETUP/STROBE/HOLD.
- FLASH read with rdybsyn held low for 10 cycles past strobe end. Expect flash_oe_n low for the extended period, then rsp_data = 0x0000_xxxx (16-bit zero-extended) and rsp_timeout = 0.
- FLASH write with rdybsyn held low forever. Expect rsp_valid with rsp_timeout = 1 after 255 WAITRDY cycles, and WE/CE released afterwards.
- Assert sys0_rst during STROBE of an SRAM write. All *_n = 1 and bus_d_oe = 0 on the next edge, with no rsp_valid. A fresh request afterwards completes normally with no TURN.
